// File: rtl/bp_nonsynth_commit_driver.sv
// Scripted commit-stream source (next-PC + retire pulse) with periodic jumps, injected stalls, hold and freeze.
// All outputs registered; first retire lands two edges after freeze drops; hold_i only gates retirement in RUN.
module bp_nonsynth_commit_driver #(
    parameter int                         vaddr_width_p  = 39,
    parameter logic [vaddr_width_p-1:0]   boot_pc_p      = vaddr_width_p'(39'h0080000000),
    parameter int                         num_instr_p    = 1024,
    parameter int                         jump_period_p  = 16,
    parameter int                         jump_offset_p  = -64,
    parameter int                         stall_period_p = 100,
    parameter int                         stall_len_p    = 8
) (
    input  logic                                                       clk_i,
    input  logic                                                       reset_n_i,
    input  logic                                                       freeze_i,
    input  logic                                                       hold_i,
    output logic [vaddr_width_p-1:0]                                   npc_o,
    output logic                                                       instret_o,
    output logic [((num_instr_p < 1) ? 1 : $clog2(num_instr_p+1))-1:0] instr_cnt_o,
    output logic                                                       done_o
);

    localparam int cnt_w_lp   = (num_instr_p < 1) ? 1 : $clog2(num_instr_p + 1);
    localparam int stall_w_lp = (stall_len_p <= 1) ? 1 : $clog2(stall_len_p);
    localparam int sper_w_lp  = (stall_period_p <= 1) ? 1 : $clog2(stall_period_p);
    localparam int jper_w_lp  = (jump_period_p <= 1) ? 1 : $clog2(jump_period_p);

    localparam logic [cnt_w_lp-1:0]      cnt_one_lp    = cnt_w_lp'(1);
    localparam logic [cnt_w_lp-1:0]      num_lp        = cnt_w_lp'(num_instr_p);
    localparam logic [stall_w_lp-1:0]    stall_one_lp  = stall_w_lp'(1);
    localparam logic [stall_w_lp-1:0]    stall_last_lp = stall_w_lp'((stall_len_p > 0) ? stall_len_p - 1 : 0);
    localparam logic [sper_w_lp-1:0]     sper_one_lp   = sper_w_lp'(1);
    localparam logic [sper_w_lp-1:0]     sper_last_lp  = sper_w_lp'((stall_period_p > 0) ? stall_period_p - 1 : 0);
    localparam logic [jper_w_lp-1:0]     jper_one_lp   = jper_w_lp'(1);
    localparam logic [jper_w_lp-1:0]     jper_last_lp  = jper_w_lp'((jump_period_p > 0) ? jump_period_p - 1 : 0);
    localparam logic [vaddr_width_p-1:0] pc_step_lp    = vaddr_width_p'(4);
    // Size cast of a signed int sign-extends, so negative offsets wrap modulo 2^vaddr_width_p.
    localparam logic [vaddr_width_p-1:0] jump_off_lp   = vaddr_width_p'(jump_offset_p);

    if (num_instr_p < 1) begin : g_bad_num_instr
        $fatal(1, "bp_nonsynth_commit_driver: num_instr_p must be >= 1");
    end
    if (stall_len_p < 1) begin : g_bad_stall_len
        $fatal(1, "bp_nonsynth_commit_driver: stall_len_p must be >= 1");
    end

    typedef enum logic [1:0] {
        S_FROZEN = 2'd0,
        S_RUN    = 2'd1,
        S_STALL  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    r_state,     w_state_n;
    logic [vaddr_width_p-1:0]  r_npc,       w_npc_n;
    logic                      r_instret,   w_instret_n;
    logic [cnt_w_lp-1:0]       r_cnt,       w_cnt_n;
    logic                      r_done,      w_done_n;
    logic [stall_w_lp-1:0]     r_stall_cnt, w_stall_cnt_n;
    logic [sper_w_lp-1:0]      r_sper_cnt,  w_sper_cnt_n;
    logic [jper_w_lp-1:0]      r_jper_cnt,  w_jper_cnt_n;
    logic [cnt_w_lp-1:0]       w_cnt_inc;
    logic                      w_jump_hit;
    logic                      w_stall_hit;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_FROZEN;
            r_npc       <= boot_pc_p;
            r_instret   <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_stall_cnt <= '0;
            r_sper_cnt  <= '0;
            r_jper_cnt  <= '0;
        end else begin
            r_state     <= w_state_n;
            r_npc       <= w_npc_n;
            r_instret   <= w_instret_n;
            r_cnt       <= w_cnt_n;
            r_done      <= w_done_n;
            r_stall_cnt <= w_stall_cnt_n;
            r_sper_cnt  <= w_sper_cnt_n;
            r_jper_cnt  <= w_jper_cnt_n;
        end
    end

    // Jump/stall cadence counters track retirements modulo their period since the last freeze.
    always_comb begin
        w_state_n     = r_state;
        w_npc_n       = r_npc;
        w_instret_n   = 1'b0;
        w_cnt_n       = r_cnt;
        w_done_n      = r_done;
        w_stall_cnt_n = r_stall_cnt;
        w_sper_cnt_n  = r_sper_cnt;
        w_jper_cnt_n  = r_jper_cnt;
        w_cnt_inc     = r_cnt + cnt_one_lp;
        w_jump_hit    = (jump_period_p != 0) && (r_jper_cnt == jper_last_lp);
        w_stall_hit   = (stall_period_p != 0) && (r_sper_cnt == sper_last_lp);

        if (freeze_i) begin
            w_state_n     = S_FROZEN;
            w_npc_n       = boot_pc_p;
            w_cnt_n       = '0;
            w_done_n      = 1'b0;
            w_stall_cnt_n = '0;
            w_sper_cnt_n  = '0;
            w_jper_cnt_n  = '0;
        end else begin
            unique case (r_state)
                S_FROZEN: w_state_n = S_RUN;
                S_DONE:   w_done_n  = 1'b1;
                S_STALL: begin
                    if (r_stall_cnt == stall_last_lp) begin
                        w_state_n     = S_RUN;
                        w_stall_cnt_n = '0;
                    end else begin
                        w_stall_cnt_n = r_stall_cnt + stall_one_lp;
                    end
                end
                S_RUN: begin
                    if (!hold_i) begin
                        w_instret_n  = 1'b1;
                        w_cnt_n      = w_cnt_inc;
                        w_npc_n      = w_jump_hit ? (r_npc + jump_off_lp) : (r_npc + pc_step_lp);
                        w_jper_cnt_n = w_jump_hit ? '0 : (r_jper_cnt + jper_one_lp);
                        w_sper_cnt_n = w_stall_hit ? '0 : (r_sper_cnt + sper_one_lp);
                        if (w_cnt_inc == num_lp) begin
                            w_state_n = S_DONE;
                        end else if (w_stall_hit) begin
                            w_state_n     = S_STALL;
                            w_stall_cnt_n = '0;
                        end
                    end
                end
                default: w_state_n = S_FROZEN;
            endcase
        end
    end

    assign npc_o       = r_npc;
    assign instret_o   = r_instret;
    assign instr_cnt_o = r_cnt;
    assign done_o      = r_done;

    a_no_x: assert property (@(negedge clk_i) (reset_n_i === 1'b1) |-> !$isunknown({npc_o, instret_o}))
        else $error("bp_nonsynth_commit_driver: X on npc_o/instret_o");

    a_cnt_bound: assert property (@(negedge clk_i) (reset_n_i === 1'b1) |-> (instr_cnt_o <= num_lp))
        else $error("bp_nonsynth_commit_driver: instr_cnt_o exceeds num_instr_p");

endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// Cycle-level scoreboard bench: a reference model pushes expected outputs per edge, compared one edge later.
module tb_bp_nonsynth_commit_driver;

    localparam int               VW     = 39;
    localparam logic [VW-1:0]    BOOT   = 39'h7F_FFFF_FFF8;
    localparam int               NUM    = 10;
    localparam int               JPER   = 4;
    localparam int               JOFF   = -64;
    localparam int               SPER   = 3;
    localparam int               SLEN   = 5;
    localparam int               CW     = $clog2(NUM + 1);

    localparam int M_FROZEN = 0;
    localparam int M_RUN    = 1;
    localparam int M_STALL  = 2;
    localparam int M_DONE   = 3;

    typedef struct packed {
        logic [VW-1:0] npc;
        logic          instret;
        logic [CW-1:0] cnt;
        logic          done;
    } exp_t;

    logic          clk_i;
    logic          reset_n_i;
    logic          freeze_i;
    logic          hold_i;
    logic [VW-1:0] npc_o;
    logic          instret_o;
    logic [CW-1:0] instr_cnt_o;
    logic          done_o;

    int checks;
    int errors;
    exp_t sb_q[$];

    int            m_state;
    logic [VW-1:0] m_npc;
    int            m_cnt;
    logic          m_done;
    logic          m_instret;
    int            m_stall_left;

    bp_nonsynth_commit_driver #(
        .vaddr_width_p  (VW),
        .boot_pc_p      (BOOT),
        .num_instr_p    (NUM),
        .jump_period_p  (JPER),
        .jump_offset_p  (JOFF),
        .stall_period_p (SPER),
        .stall_len_p    (SLEN)
    ) u_dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .freeze_i    (freeze_i),
        .hold_i      (hold_i),
        .npc_o       (npc_o),
        .instret_o   (instret_o),
        .instr_cnt_o (instr_cnt_o),
        .done_o      (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state      = M_FROZEN;
        m_npc        = BOOT;
        m_cnt        = 0;
        m_done       = 1'b0;
        m_instret    = 1'b0;
        m_stall_left = 0;
    endtask

    task automatic model_edge(input logic f, input logic h);
        m_instret = 1'b0;
        if (f) begin
            model_reset();
        end else begin
            case (m_state)
                M_FROZEN: m_state = M_RUN;
                M_DONE:   m_done  = 1'b1;
                M_STALL: begin
                    m_stall_left--;
                    if (m_stall_left == 0) m_state = M_RUN;
                end
                default: begin
                    if (!h) begin
                        m_instret = 1'b1;
                        m_cnt++;
                        if (JPER != 0 && (m_cnt % JPER) == 0)
                            m_npc = (JOFF < 0) ? (m_npc - VW'(-JOFF)) : (m_npc + VW'(JOFF));
                        else
                            m_npc = m_npc + VW'(4);
                        if (m_cnt == NUM) begin
                            m_state = M_DONE;
                        end else if (SPER != 0 && (m_cnt % SPER) == 0) begin
                            m_state      = M_STALL;
                            m_stall_left = SLEN;
                        end
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle of stimulus, push the model's post-edge outputs, then compare after the edge.
    task automatic step(input logic f, input logic h);
        exp_t e;
        freeze_i = f;
        hold_i   = h;
        model_edge(f, h);
        e.npc     = m_npc;
        e.instret = m_instret;
        e.cnt     = CW'(m_cnt);
        e.done    = m_done;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        chk("npc",     {25'b0, npc_o},      {25'b0, e.npc});
        chk("instret", {63'b0, instret_o},  {63'b0, e.instret});
        chk("cnt",     {{(64-CW){1'b0}}, instr_cnt_o}, {{(64-CW){1'b0}}, e.cnt});
        chk("done",    {63'b0, done_o},     {63'b0, e.done});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_npc"},     {25'b0, npc_o}, {25'b0, BOOT});
        chk({tag, "_instret"}, {63'b0, instret_o}, 64'd0);
        chk({tag, "_cnt"},     {{(64-CW){1'b0}}, instr_cnt_o}, 64'd0);
        chk({tag, "_done"},    {63'b0, done_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        reset_n_i = 1'b0;
        freeze_i  = 1'b1;
        hold_i    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_vals("por");
        reset_n_i = 1'b1;

        // Held freeze keeps the boot state; then the first run with wrap and a stall.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("no_retire_on_release", {63'b0, instret_o}, 64'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("wrap_to_zero", {25'b0, npc_o}, 64'd0);
        step(1'b0, 1'b0);
        for (int i = 0; i < SLEN; i++) step(1'b0, (i % 2) == 0);
        step(1'b0, 1'b0);
        chk("jump_backwards_wrap", {25'b0, npc_o}, {25'b0, 39'h7F_FFFF_FFC4});
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("after_hold_npc", {25'b0, npc_o}, {25'b0, 39'h7F_FFFF_FFC8});

        // Freeze at instr_cnt 5, then replay to DONE with sporadic hold.
        step(1'b1, 1'b0);
        chk_reset_vals("freeze_mid");
        for (int i = 0; i < 60; i++) step(1'b0, (i % 7) == 5);
        chk("done_reached", {63'b0, done_o}, 64'd1);
        chk("done_cnt", {{(64-CW){1'b0}}, instr_cnt_o}, 64'(NUM));

        // Freeze out of DONE, run into a stall, then async reset mid-stall.
        step(1'b1, 1'b0);
        chk_reset_vals("freeze_done");
        n = 0;
        while (m_state != M_STALL && n < 30) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("reach_stall_in_budget", {63'b0, (m_state == M_STALL)}, 64'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        chk_reset_vals("rst_held");
        freeze_i  = 1'b0;
        reset_n_i = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_commit_driver.md
Name: bp_nonsynth_commit_driver

Overview:
- Nonsynth testbench source for the per-core commit stream (next-PC plus instruction-retired pulse), i.e. the producer side of what the core watchdog and commit tracers consume.
- Generates a scripted, deterministic PC and retire sequence with periodic jumps, injected stalls, external hold and freeze. Harness tests can therefore exercise commit-stream consumers (watchdog, heartbeat, tracers) without a full core.

Parameters:
- vaddr_width_p, 39, width of npc_o.
- boot_pc_p, 39'h0080000000, PC after reset/freeze.
- num_instr_p, 1024, retirements before done; must be >= 1.
- jump_period_p, 16, every Nth retirement takes a jump instead of +4; 0 disables jumps.
- jump_offset_p, -64, signed byte offset applied on a jump.
- stall_period_p, 100, retirements between injected stalls; 0 disables stalls.
- stall_len_p, 8, cycles per injected stall; must be >= 1.

Ports:
- clk_i, in, 1, clock.
- reset_n_i, in, 1, asynchronous active-low reset.
- freeze_i, in, 1, core frozen; restarts the sequence from boot.
- hold_i, in, 1, external backpressure; suppresses retirement this cycle.
- npc_o, out, vaddr_width_p, current next-PC (registered).
- instret_o, out, 1, one-cycle retire pulse per instruction (registered).
- instr_cnt_o, out, BSG_SAFE_CLOG2(num_instr_p+1), retirements so far (registered).
- done_o, out, 1, sequence complete (registered, sticky until freeze/reset).

Behaviour:
- Outputs:
  - All outputs are flops. No combinational input-to-output path.
  - Async reset (reset_n_i low) takes effect immediately, including mid-sequence: npc_o=boot_pc_p, instret_o=0, instr_cnt_o=0, done_o=0, state=FROZEN, stall counters=0.
- States: FROZEN, RUN, STALL, DONE.
- Priority each edge: freeze > done > stall > hold > retire.
- freeze_i=1 in any state:
  - Next state FROZEN; npc_o<=boot_pc_p, instret_o<=0, instr_cnt_o<=0, done_o<=0, stall counters cleared.
- FROZEN with freeze_i=0:
  - Next state RUN; no retire on this edge.
  - First possible instret_o pulse is 2 edges after freeze_i deasserts.
- RUN, hold_i=0 (retire edge):
  - instret_o<=1, instr_cnt_o<=cnt+1.
  - npc_o<=npc+jump_offset_p if jump_period_p!=0 and (cnt+1)%jump_period_p==0, else npc+4.
  - Arithmetic is modulo 2^vaddr_width_p; the offset is sign-extended and wraps silently.
  - If cnt+1==num_instr_p: next state DONE; this final retire still pulses.
  - Else if stall_period_p!=0 and (cnt+1)%stall_period_p==0: next state STALL, stall_cnt<=0.
- RUN, hold_i=1:
  - instret_o<=0; npc_o, instr_cnt_o and the stall-period count hold.
- STALL:
  - instret_o<=0, npc_o held, hold_i ignored.
  - stall_cnt increments each edge; when stall_cnt==stall_len_p-1, next state RUN.
  - Exactly stall_len_p cycles with instret_o=0.
- DONE:
  - done_o<=1, instret_o<=0, npc_o held at the last value.
  - Leaves only via freeze or reset.
- Invariants:
  - instret_o never high in two cycles that have no npc_o update.
  - instr_cnt_o never exceeds num_instr_p.
  - npc_o changes only on retire edges, freeze and reset.
- Nonsynth checks, evaluated on negedge when reset_n_i===1:
  - $error if npc_o or instret_o is X.
  - $fatal at elaboration if num_instr_p==0 or stall_len_p==0.

Test Plan:
- Basic run (jumps and stalls disabled, num_instr_p=8, boot 0x80000000, hold=0, freeze released at cycle 0):
  - instret_o high on cycles 2..9.
  - npc_o steps 0x80000000->...->0x80000020.
  - done_o=1 from cycle 10; instr_cnt_o=8 and held.
- Jump (jump_period_p=4, offset -64):
  - 4th retire sets npc_o=0x8000000C-0x40=0x7FFFFFCC.
  - Next retire sets npc_o=0x7FFFFFD0.
- Stall (stall_period_p=3, stall_len_p=5):
  - After 3rd retire, exactly 5 cycles with instret_o=0 and npc_o constant.
  - Retire resumes on the 6th cycle.
  - hold_i=1 during the stall has no effect.
- Hold (hold_i=1 for 4 cycles mid-RUN):
  - instret_o=0 and npc_o, instr_cnt_o frozen for those 4 cycles.
  - Resumes with the same next PC.
- Freeze mid-run and in DONE:
  - freeze_i pulse at instr_cnt_o=5 gives npc_o=boot, instr_cnt_o=0, done_o=0 next edge.
  - Sequence then replays identically.
  - Same check from DONE.
- Async reset mid-STALL:
  - reset_n_i low between edges clears all outputs immediately (before the next edge).
  - After release, the sequence restarts from FROZEN.
  - PC wrap: boot_pc_p=2^39-4 with +4 gives npc_o=0.
